// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with selectable read mode, registered status flags,
// occupancy count and sticky overflow/underflow indicators.
module fifo_param #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned LOOKAHEAD     = 0,
  parameter int unsigned AFULL_THRESH  = (1 << DEPTH_LOG2) - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned Cw    = DEPTH_LOG2 + 1;
  localparam logic [Cw-1:0] One = Cw'(1);

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [Cw-1:0]         wr_ptr_q, wr_ptr_d;
  logic [Cw-1:0]         rd_ptr_q, rd_ptr_d;
  logic [Cw-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en, rd_en;

  assign rd_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    // Acceptance is judged on the registered flags, so wr/rd never reach a flag combinationally.
    wr_en    = wr && !full_q;
    rd_en    = rd && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + One;
    if (rd_en) rd_ptr_d = rd_ptr_q + One;
    if (wr_en && !rd_en) begin
      count_d = count_q + One;
    end else if (rd_en && !wr_en) begin
      count_d = count_q - One;
    end
    full_d   = (wr_ptr_d[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]) &&
               (wr_ptr_d[DEPTH_LOG2] != rd_ptr_d[DEPTH_LOG2]);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    afull_d  = 32'(count_d) >= AFULL_THRESH;
    aempty_d = 32'(count_d) <= AEMPTY_THRESH;
    ovf_d    = ovf_q | (wr & full_q);
    udf_d    = udf_q | (rd & empty_q);
    dout_d   = dout_q;
    if ((LOOKAHEAD == 0) && rd_en) dout_d = rd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AFULL_THRESH == 0);
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dout_q   <= dout_d;
    end
  end

  // Writes are blocked during reset so nothing lands in storage while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
  end

  assign dout         = (LOOKAHEAD != 0) ? (empty_q ? '0 : rd_data) : dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: a 16-deep registered-read instance and a 4-deep lookahead instance
// share one stimulus stream; each is checked against its own queue model and scoreboard.
module tb_fifo_param;

  localparam int unsigned DW       = 32;
  localparam int unsigned ALog2    = 4;
  localparam int unsigned BLog2    = 2;
  localparam int          ADepth   = 16;
  localparam int          BDepth   = 4;
  localparam int          AAfull   = 14;
  localparam int          BAfull   = 2;
  localparam int          AeThresh = 2;

  logic          clk = 1'b0;
  logic          rst_n, wr, rd;
  logic [DW-1:0] din;

  logic          a_full, a_afull, a_empty, a_aempty, a_ovf, a_udf;
  logic [DW-1:0] a_dout;
  logic [ALog2:0] a_count;
  logic          b_full, b_afull, b_empty, b_aempty, b_ovf, b_udf;
  logic [DW-1:0] b_dout;
  logic [BLog2:0] b_count;

  int            n_tests, n_fail;
  int            cnt_a, cnt_b;
  bit            ovf_a, udf_a, ovf_b, udf_b;
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];
  logic          take_a = 1'b0;

  always #5 clk = ~clk;

  fifo_param #(
    .DATA_WIDTH(DW), .DEPTH_LOG2(ALog2), .LOOKAHEAD(0),
    .AFULL_THRESH(AAfull), .AEMPTY_THRESH(AeThresh)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .full(a_full), .almost_full(a_afull),
    .rd(rd), .dout(a_dout), .empty(a_empty), .almost_empty(a_aempty), .count(a_count),
    .overflow(a_ovf), .underflow(a_udf)
  );

  fifo_param #(
    .DATA_WIDTH(DW), .DEPTH_LOG2(BLog2), .LOOKAHEAD(1),
    .AFULL_THRESH(BAfull), .AEMPTY_THRESH(AeThresh)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .full(b_full), .almost_full(b_afull),
    .rd(rd), .dout(b_dout), .empty(b_empty), .almost_empty(b_aempty), .count(b_count),
    .overflow(b_ovf), .underflow(b_udf)
  );

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: occupancy as an integer, contents as the scoreboard queues.
  task automatic model_step(input logic w, input logic r, input logic [DW-1:0] d);
    bit wa, ra;
    wa = w && (cnt_a < ADepth);
    ra = r && (cnt_a > 0);
    if (w && !wa) ovf_a = 1'b1;
    if (r && !ra) udf_a = 1'b1;
    if (wa) exp_a.push_back(d);
    cnt_a = cnt_a + int'(wa) - int'(ra);
    wa = w && (cnt_b < BDepth);
    ra = r && (cnt_b > 0);
    if (w && !wa) ovf_b = 1'b1;
    if (r && !ra) udf_b = 1'b1;
    if (wa) exp_b.push_back(d);
    cnt_b = cnt_b + int'(wa) - int'(ra);
  endtask

  task automatic check_state();
    check("a_count", DW'(a_count), DW'(cnt_a));
    check("a_flags", DW'({a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf}),
          DW'({cnt_a == ADepth, cnt_a == 0, cnt_a >= AAfull, cnt_a <= AeThresh, ovf_a, udf_a}));
    check("b_count", DW'(b_count), DW'(cnt_b));
    check("b_flags", DW'({b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf}),
          DW'({cnt_b == BDepth, cnt_b == 0, cnt_b >= BAfull, cnt_b <= AeThresh, ovf_b, udf_b}));
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    wr  = w;
    rd  = r;
    din = d;
    model_step(w, r, d);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr    = 1'b1;
    rd    = 1'b0;
    din   = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr    = 1'b0;
    cnt_a = 0; cnt_b = 0;
    ovf_a = 1'b0; udf_a = 1'b0; ovf_b = 1'b0; udf_b = 1'b0;
    exp_a.delete();
    exp_b.delete();
    check_state();
    check("a_dout_rst", a_dout, '0);
  endtask

  // Registered-read instance: data appears the cycle after the DUT accepts a read.
  always @(posedge clk) take_a <= rst_n && rd && !a_empty;

  always @(negedge clk) begin
    if (take_a) begin
      if (exp_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_sb_extra: got read data %0h expected none", a_dout);
      end else begin
        check("a_dout", a_dout, exp_a.pop_front());
      end
    end
    // Lookahead instance: the word shown now is the one the coming edge pops.
    if (rst_n && rd && !b_empty) begin
      if (exp_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_sb_extra: got read data %0h expected none", b_dout);
      end else begin
        check("b_dout", b_dout, exp_b.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] v;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
    cnt_a = 0; cnt_b = 0;

    do_reset();

    v = 8'h5A;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, {24'h0, v});
      v = v + 8'h9C;
      if (i == 13) check("a_afull14", DW'(a_afull), DW'(1));
    end
    check("a_full16", DW'(a_full), DW'(1));
    step(1'b1, 1'b0, 32'hEE);
    check("a_ovf17", DW'(a_ovf), DW'(1));
    repeat (16) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    check("a_empty_drained", DW'(a_empty), DW'(1));

    do_reset();
    step(1'b1, 1'b0, 32'hC4);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    check("a_dout_c4", a_dout, 32'hC4);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("a_dout_hold", a_dout, 32'hC4);

    do_reset();
    step(1'b1, 1'b0, 32'h81);
    check("b_empty_fall", DW'(b_empty), DW'(0));
    check("b_dout_81", b_dout, 32'h81);
    step(1'b1, 1'b0, 32'h82);
    check("b_dout_head", b_dout, 32'h81);
    step(1'b0, 1'b1, '0);
    check("b_dout_next", b_dout, 32'h82);

    do_reset();
    repeat (16) step(1'b1, 1'b0, $urandom);
    step(1'b1, 1'b1, 32'h1234);
    // The read still drains one entry; the write is the one dropped.
    check("a_full_wrrd_cnt", DW'(a_count), DW'(ADepth - 1));
    check("a_full_wrrd_ovf", DW'(a_ovf), DW'(1));
    repeat (16) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 32'h5678);
    check("a_empty_wrrd_cnt", DW'(a_count), DW'(1));
    check("a_empty_wrrd_udf", DW'(a_udf), DW'(1));
    repeat (2) step(1'b0, 1'b1, '0);

    do_reset();
    for (int i = 0; i < 1024; i++) step(1'b1, 1'($urandom_range(0, 1)), $urandom);
    repeat (20) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    check("a_sb_left", DW'(exp_a.size()), '0);
    check("b_sb_left", DW'(exp_b.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
